// File: rtl/pcie_pkg.sv
// Shared constants and types for the PCIe transaction block arbitration logic.
package pcie_pkg;

  localparam int unsigned NREQ = 4;
  localparam int unsigned WW   = 3;
  localparam logic [WW-1:0] DEF_WEIGHT = 3'd1;

  // Destination field of an ingress FIFO head word.
  localparam int unsigned DEST_HI = 9;
  localparam int unsigned DEST_LO = 8;
  localparam int unsigned DEST_W  = DEST_HI - DEST_LO + 1;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set bit of req scanning ptr, ptr+1, ... mod 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       valid
);

  // Rotating priority scan starting at ptr; lowest offset wins.
  always_comb begin
    logic [1:0] cand;
    logic       found;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    valid = found;
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin scheduler from ingress FIFO0-3 to egress FIFO4-7.
// Optional macro WRR_STRICT_PRIO0_EN: FIFO0 gets strict priority and may cut
// other bursts short; the round-robin pointer then rotates among 1..3 only.
module wrr_arbiter
  import pcie_pkg::*;
#(
  parameter int unsigned   NREQ       = pcie_pkg::NREQ,
  parameter int unsigned   WW         = pcie_pkg::WW,
  parameter logic [WW-1:0] DEF_WEIGHT = pcie_pkg::DEF_WEIGHT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_load,
  input  logic [WW-1:0]     weight0,
  input  logic [WW-1:0]     weight1,
  input  logic [WW-1:0]     weight2,
  input  logic [WW-1:0]     weight3,
  input  logic [3:0]        empty,
  input  logic [DEST_W-1:0] head_dest0,
  input  logic [DEST_W-1:0] head_dest1,
  input  logic [DEST_W-1:0] head_dest2,
  input  logic [DEST_W-1:0] head_dest3,
  input  logic [3:0]        afull,
  output logic [3:0]        pop,
  output logic [3:0]        push,
  output logic [1:0]        sel,
  output logic [1:0]        dest,
  output logic              busy
);

  logic [WW-1:0]     weight_q [NREQ];
  logic [DEST_W-1:0] hd [NREQ];
  logic [3:0]        elig;
  logic [3:0]        pick_req;
  logic [1:0]        pick_idx;
  logic              pick_valid;
  logic [1:0]        grant_idx;
  logic              grant_valid;

  state_t        state, state_n;
  logic [1:0]    rr_ptr, rr_ptr_n;
  logic [1:0]    cur, cur_n;
  logic [WW-1:0] cnt, cnt_n;
  logic          done;

  // Head-of-line eligibility: data present and destination not almost full.
  always_comb begin
    hd[0] = head_dest0;
    hd[1] = head_dest1;
    hd[2] = head_dest2;
    hd[3] = head_dest3;
    elig  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      elig[i] = !empty[i] && !afull[hd[i]];
    end
  end

`ifdef WRR_STRICT_PRIO0_EN
  assign pick_req = {elig[3:1], 1'b0};
`else
  assign pick_req = elig;
`endif

  rr_pick4 u_pick (
    .req   (pick_req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Grant candidate for the ARB state.
  always_comb begin
`ifdef WRR_STRICT_PRIO0_EN
    if (elig[0]) begin
      grant_idx   = 2'd0;
      grant_valid = 1'b1;
    end else begin
      grant_idx   = pick_idx;
      grant_valid = pick_valid;
    end
`else
    grant_idx   = pick_idx;
    grant_valid = pick_valid;
`endif
  end

  // Next-state, burst counting and combinational pop strobe.
  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    cur_n    = cur;
    cnt_n    = cnt;
    pop      = '0;
    done     = 1'b0;
    case (state)
      ARB: begin
        if (enable && grant_valid) begin
          state_n = BURST;
          cur_n   = grant_idx;
          cnt_n   = weight_q[grant_idx];
        end
      end
      BURST: begin
        if (enable && elig[cur]) begin
          pop = onehot4(cur);
        end
        if (|pop && cnt != '0) begin
          cnt_n = cnt - WW'(1);
        end
        done = (|pop && cnt == '0) || !elig[cur] || !enable;
`ifdef WRR_STRICT_PRIO0_EN
        done = done || (cur != 2'd0 && elig[0]);
`endif
        if (done) begin
          state_n = ARB;
`ifdef WRR_STRICT_PRIO0_EN
          if (cur != 2'd0) begin
            rr_ptr_n = (cur == 2'd3) ? 2'd1 : cur + 2'd1;
          end
`else
          rr_ptr_n = cur + 2'd1;
`endif
        end
      end
      default: state_n = ARB;
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ARB;
      rr_ptr <= '0;
      cur    <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      rr_ptr <= rr_ptr_n;
      cur    <= cur_n;
      cnt    <= cnt_n;
    end
  end

  // Weight registers; a new load affects only subsequent grants.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        weight_q[i] <= DEF_WEIGHT;
      end
    end else if (cfg_load) begin
      weight_q[0] <= weight0;
      weight_q[1] <= weight1;
      weight_q[2] <= weight2;
      weight_q[3] <= weight3;
    end
  end

  // Egress push one cycle after each pop; sel/dest hold until the next push.
  always_ff @(posedge clk) begin
    if (!reset) begin
      push <= '0;
      sel  <= '0;
      dest <= '0;
    end else begin
      push <= (|pop) ? onehot4(hd[cur]) : '0;
      if (|pop) begin
        sel  <= cur;
        dest <= hd[cur];
      end
    end
  end

  assign busy = (state == BURST) || (|push);

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: directed scenarios plus randomized
// traffic checked against a words-remaining grant model.
module tb_wrr_arbiter;

  logic       clk = 1'b0;
  logic       reset, enable, cfg_load;
  logic [2:0] weight0, weight1, weight2, weight3;
  logic [3:0] empty, afull;
  logic [1:0] hd [4];
  logic [3:0] pop, push;
  logic [1:0] sel, dest;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int q [4][$];

  always #5 clk = ~clk;

  wrr_arbiter #(.NREQ(4), .WW(3), .DEF_WEIGHT(3'd1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_load(cfg_load),
    .weight0(weight0), .weight1(weight1), .weight2(weight2), .weight3(weight3),
    .empty(empty), .head_dest0(hd[0]), .head_dest1(hd[1]),
    .head_dest2(hd[2]), .head_dest3(hd[3]), .afull(afull),
    .pop(pop), .push(push), .sel(sel), .dest(dest), .busy(busy)
  );

  // Present each FIFO's emptiness and head destination.
  task automatic apply_fifos();
    for (int i = 0; i < 4; i++) begin
      empty[i] = (q[i].size() == 0);
      hd[i]    = (q[i].size() != 0) ? 2'(q[i][0]) : 2'd0;
    end
  endtask

  // Advance one clock; the ingress FIFOs drop their head on a pop.
  task automatic step();
    logic [3:0] p;
    p = pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (p[i] && q[i].size() > 0) void'(q[i].pop_front());
    apply_fifos();
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; cfg_load = 1'b0; afull = '0;
    weight0 = 3'd1; weight1 = 3'd1; weight2 = 3'd1; weight3 = 3'd1;
    for (int i = 0; i < 4; i++) q[i].delete();
    apply_fifos();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic load_weights(input int w0, input int w1, input int w2, input int w3);
    weight0 = 3'(w0); weight1 = 3'(w1); weight2 = 3'(w2); weight3 = 3'(w3);
    cfg_load = 1'b1;
    apply_fifos();
    #4;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      apply_fifos();
      #4;
      total++; if (pop !== 4'b0)  begin bad++; $display("FAIL reset_pop cyc=%0d got=%b want=0000", c, pop); end
      total++; if (push !== 4'b0) begin bad++; $display("FAIL reset_push cyc=%0d got=%b want=0000", c, push); end
      total++; if ({sel, dest} !== 4'b0) begin bad++; $display("FAIL reset_seldest cyc=%0d got=%b want=0000", c, {sel, dest}); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy cyc=%0d got=%b want=0", c, busy); end
      step();
    end
  endtask

  task automatic test_single();
    bit on   [10] = '{0, 1, 1, 0, 1, 1, 0, 1, 0, 0};
    bit bsy  [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    bit prev = 0;
    logic [3:0] want;
    do_reset();
    load_weights(1, 1, 1, 1);
    repeat (5) q[2].push_back(1);
    enable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      apply_fifos();
      #4;
      want = on[c] ? 4'b0100 : 4'b0000;
      total++; if (pop !== want) begin bad++; $display("FAIL single_pop cyc=%0d got=%b want=%b", c, pop, want); end
      want = prev ? 4'b0010 : 4'b0000;
      total++; if (push !== want) begin bad++; $display("FAIL single_push cyc=%0d got=%b want=%b", c, push, want); end
      if (prev) begin
        total++; if ({sel, dest} !== {2'd2, 2'd1}) begin bad++; $display("FAIL single_seldest cyc=%0d got=%b want=1001", c, {sel, dest}); end
      end
      total++; if (busy !== bsy[c]) begin bad++; $display("FAIL single_busy cyc=%0d got=%b want=%b", c, busy, bsy[c]); end
      prev = on[c];
      step();
    end
  endtask

  task automatic test_four();
    int order [5] = '{0, 1, 2, 3, 0};
    int wts   [4] = '{0, 1, 2, 3};
    int e[$];
    int prev = -1;
    logic [3:0] want;
    do_reset();
    load_weights(0, 1, 2, 3);
    for (int i = 0; i < 4; i++) repeat (12) q[i].push_back(i);
    foreach (order[g]) begin
      e.push_back(-1);
      repeat (wts[order[g]] + 1) e.push_back(order[g]);
    end
    enable = 1'b1;
    for (int c = 0; c < e.size(); c++) begin
      apply_fifos();
      #4;
      want = (e[c] < 0) ? 4'b0 : 4'(1 << e[c]);
      total++; if (pop !== want) begin bad++; $display("FAIL four_pop cyc=%0d got=%b want=%b", c, pop, want); end
      want = (prev < 0) ? 4'b0 : 4'(1 << prev);
      total++; if (push !== want) begin bad++; $display("FAIL four_push cyc=%0d got=%b want=%b", c, push, want); end
      if (prev >= 0) begin
        total++; if ({sel, dest} !== {2'(prev), 2'(prev)}) begin bad++; $display("FAIL four_seldest cyc=%0d got=%b want=%b", c, {sel, dest}, {2'(prev), 2'(prev)}); end
      end
      prev = e[c];
      step();
    end
  endtask

  task automatic test_backpressure();
    int e  [11] = '{-1, 0, 0, -1, 0, 0, -1, 1, 1, -1, 0};
    int dm [4]  = '{0, 3, 0, 0};
    int prev = -1;
    logic [3:0] want;
    do_reset();
    repeat (5) q[0].push_back(0);
    repeat (3) q[1].push_back(3);
    enable = 1'b1;
    for (int c = 0; c < 11; c++) begin
      afull = (c < 6) ? 4'b1000 : 4'b0000;
      apply_fifos();
      #4;
      want = (e[c] < 0) ? 4'b0 : 4'(1 << e[c]);
      total++; if (pop !== want) begin bad++; $display("FAIL bp_pop cyc=%0d got=%b want=%b", c, pop, want); end
      want = (prev < 0) ? 4'b0 : 4'(1 << dm[prev]);
      total++; if (push !== want) begin bad++; $display("FAIL bp_push cyc=%0d got=%b want=%b", c, push, want); end
      if (prev >= 0) begin
        total++; if ({sel, dest} !== {2'(prev), 2'(dm[prev])}) begin bad++; $display("FAIL bp_seldest cyc=%0d got=%b want=%b", c, {sel, dest}, {2'(prev), 2'(dm[prev])}); end
      end
      prev = e[c];
      step();
    end
  endtask

  task automatic test_midburst_enable();
    bit on  [7] = '{0, 1, 1, 0, 0, 0, 1};
    bit en  [7] = '{1, 1, 1, 0, 0, 1, 1};
    bit bsy [7] = '{0, 1, 1, 1, 0, 0, 1};
    bit prev = 0;
    logic [3:0] want;
    do_reset();
    load_weights(3, 1, 1, 1);
    repeat (8) q[0].push_back(2);
    for (int c = 0; c < 7; c++) begin
      enable = en[c];
      apply_fifos();
      #4;
      want = on[c] ? 4'b0001 : 4'b0000;
      total++; if (pop !== want) begin bad++; $display("FAIL en_pop cyc=%0d got=%b want=%b", c, pop, want); end
      want = prev ? 4'b0100 : 4'b0000;
      total++; if (push !== want) begin bad++; $display("FAIL en_push cyc=%0d got=%b want=%b", c, push, want); end
      total++; if (busy !== bsy[c]) begin bad++; $display("FAIL en_busy cyc=%0d got=%b want=%b", c, busy, bsy[c]); end
      prev = on[c];
      step();
    end
  endtask

  task automatic test_midburst_reset();
    do_reset();
    load_weights(1, 3, 1, 1);
    repeat (8) q[1].push_back(2);
    enable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      apply_fifos();
      #4;
      total++; if (pop !== ((c == 0) ? 4'b0000 : 4'b0010)) begin bad++; $display("FAIL rst_pop cyc=%0d got=%b", c, pop); end
      step();
    end
    reset = 1'b0;
    #4;
    step();
    #4;
    total++; if (pop !== 4'b0)  begin bad++; $display("FAIL rst_mid_pop got=%b want=0000", pop); end
    total++; if (push !== 4'b0) begin bad++; $display("FAIL rst_mid_push got=%b want=0000", push); end
    total++; if ({sel, dest} !== 4'b0) begin bad++; $display("FAIL rst_mid_seldest got=%b want=0000", {sel, dest}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    step();
    reset = 1'b1;
  endtask

`ifdef WRR_STRICT_PRIO0_EN
  task automatic test_strict();
    int e [5] = '{-1, 3, 3, -1, 0};
    logic [3:0] want;
    do_reset();
    load_weights(1, 1, 1, 3);
    repeat (8) q[3].push_back(1);
    enable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin q[0].push_back(0); q[0].push_back(0); end
      apply_fifos();
      #4;
      want = (e[c] < 0) ? 4'b0 : 4'(1 << e[c]);
      total++; if (pop !== want) begin bad++; $display("FAIL strict_pop cyc=%0d got=%b want=%b", c, pop, want); end
      step();
    end
  endtask
`endif

  task automatic test_random();
    bit gr = 0;
    int who = 0, left = 0, ptr = 0;
    int wt [4] = '{1, 1, 1, 1};
    logic [3:0] m_push = '0;
    logic [1:0] m_sel = '0, m_dest = '0;
    bit elig [4];
    bit strict;
    bit p, fin, exp_busy;
    int g;
    logic [3:0] exp_pop;
`ifdef WRR_STRICT_PRIO0_EN
    strict = 1;
`else
    strict = 0;
`endif
    do_reset();
    for (int c = 0; c < 600; c++) begin
      enable   = ($urandom_range(0, 9) != 0);
      cfg_load = ($urandom_range(0, 9) == 0);
      weight0 = 3'($urandom); weight1 = 3'($urandom);
      weight2 = 3'($urandom); weight3 = 3'($urandom);
      for (int i = 0; i < 4; i++) begin
        afull[i] = ($urandom_range(0, 3) == 0);
        if (q[i].size() < 6 && $urandom_range(0, 9) < 3) q[i].push_back(int'($urandom_range(0, 3)));
      end
      apply_fifos();
      for (int i = 0; i < 4; i++) elig[i] = !empty[i] && !afull[hd[i]];

      exp_busy = gr || (m_push != 0);
      exp_pop  = '0;
      p = 0;
      if (!gr) begin
        g = -1;
        if (enable) begin
          if (strict && elig[0]) g = 0;
          else for (int k = 0; k < 4; k++)
            if (g < 0 && elig[(ptr + k) % 4] && !(strict && (ptr + k) % 4 == 0)) g = (ptr + k) % 4;
        end
        if (g >= 0) begin gr = 1; who = g; left = wt[g] + 1; end
      end else begin
        p = enable && elig[who];
        if (p) begin exp_pop = 4'(1 << who); left--; end
        fin = (p && left == 0) || !elig[who] || !enable || (strict && who != 0 && elig[0]);
        if (fin) begin
          gr = 0;
          if (!strict) ptr = (who + 1) % 4;
          else if (who != 0) ptr = (who == 3) ? 1 : who + 1;
        end
      end

      #4;
      total++; if (pop !== exp_pop) begin bad++; $display("FAIL rnd_pop cyc=%0d got=%b want=%b", c, pop, exp_pop); end
      total++; if (push !== m_push) begin bad++; $display("FAIL rnd_push cyc=%0d got=%b want=%b", c, push, m_push); end
      total++; if ({sel, dest} !== {m_sel, m_dest}) begin bad++; $display("FAIL rnd_seldest cyc=%0d got=%b want=%b", c, {sel, dest}, {m_sel, m_dest}); end
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", c, busy, exp_busy); end

      if (p) begin
        m_push = 4'(1 << hd[who]); m_sel = 2'(who); m_dest = hd[who];
      end else begin
        m_push = '0;
      end
      if (cfg_load) begin
        wt[0] = int'(weight0); wt[1] = int'(weight1);
        wt[2] = int'(weight2); wt[3] = int'(weight3);
      end
      step();
    end
    cfg_load = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_four();
    test_backpressure();
    test_midburst_enable();
    test_midburst_reset();
`ifdef WRR_STRICT_PRIO0_EN
    test_strict();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
